// File: rtl/fmdsp_pkg.sv
// Shared helpers for the fmdsp datapath blocks.
package fmdsp_pkg;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid flag and a data word, loaded together on i_load.
module pipe_stage #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Data only moves with a valid word, so a bubble never overwrites what the slot holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-deep register pipeline with bubble collapsing and a combinational ready path.
// Handshake: a word moves on a port in any cycle where valid and ready are both high;
// valid never waits on ready, and a producer holds valid/data stable until the transfer.
module pipe_stage_chain
    import fmdsp_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               DEPTH      = 3,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [CW-1:0]    r_count;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             w_prev_v;
            logic [WIDTH-1:0] w_prev_d;

            // A stage may advance if it or any stage downstream of it is empty, or the sink drains.
            assign w_adv[gi] = ~(&w_v[DEPTH-1:gi]) | out_ready;

            if (gi == 0) begin : g_head
                assign w_prev_v = in_valid;
                assign w_prev_d = in_data;
            end else begin : g_body
                assign w_prev_v = w_v[gi-1];
                assign w_prev_d = w_d[gi-1];
            end

            pipe_stage #(
                .WIDTH      (WIDTH),
                .RESET_DATA (RESET_DATA)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_adv[gi]),
                .i_clear (flush),
                .i_valid (w_prev_v),
                .i_data  (w_prev_d),
                .o_valid (w_v[gi]),
                .o_data  (w_d[gi])
            );
        end
    endgenerate

    assign in_ready   = w_adv[0] & ~flush;
    assign out_valid  = w_v[DEPTH-1];
    assign out_data   = w_d[DEPTH-1];
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus a long randomized run against a slot-position model.
module tb_pipe_stage_chain;

    localparam int          WIDTH = 16;
    localparam int          DEPTH = 3;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [15:0] RDATA = 16'h0000;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [CW-1:0]    count;

    int n_checks;
    int n_errors;
    int peak_count;

    // Model: words in flight (oldest first) with the slot index each occupies.
    logic [WIDTH-1:0] exp_q[$];
    int               pos_q[$];
    logic [WIDTH-1:0] m_last;

    pipe_stage_chain #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .RESET_DATA (RDATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .count     (count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pos_q.delete();
        m_last = RDATA;
    endtask

    // Driver: present inputs for one cycle, check outputs mid-cycle, then advance the model over the edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic fl);
        logic exp_rdy;
        logic exp_ov;
        int   ceil_pos;
        int   np;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        exp_rdy = ((pos_q.size() < DEPTH) || ordy) && !fl;
        exp_ov  = (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        check_eq("out_data", 32'(out_data), 32'(m_last));
        check_eq("count", 32'(count), 32'(exp_q.size()));
        if (int'(count) > peak_count) peak_count = int'(count);
        if (exp_ov && ordy) begin
            check_eq("out_word", 32'(out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            void'(pos_q.pop_front());
        end
        if (fl) begin
            exp_q.delete();
            pos_q.delete();
        end else begin
            for (int k = 0; k < pos_q.size(); k++) begin
                ceil_pos = (k == 0) ? DEPTH - 1 : pos_q[k-1] - 1;
                np = (pos_q[k] + 1 < ceil_pos) ? pos_q[k] + 1 : ceil_pos;
                if (np == DEPTH - 1 && pos_q[k] != DEPTH - 1) m_last = exp_q[k];
                pos_q[k] = np;
            end
            if (exp_rdy && iv) begin
                exp_q.push_back(id);
                pos_q.push_back(0);
                if (DEPTH == 1) m_last = id;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, ordy, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        peak_count = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        model_reset();
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data", 32'(out_data), 32'(RDATA));
        check_eq("rst_count", 32'(count), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back stream 1..5 with the sink always ready.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(i), 1'b1, 1'b0);
        idle(4, 1'b1);
        check_eq("stream_peak", 32'(peak_count), 32'd3);
        check_eq("stream_empty", 32'(count), 32'h0);

        // Stall: fill with the sink blocked, then release with DDDD still offered.
        cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBBB, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCCC, 1'b0, 1'b0);
        cycle(1'b1, 16'hDDDD, 1'b0, 1'b0);
        cycle(1'b1, 16'hDDDD, 1'b0, 1'b0);
        #3;
        check_eq("full_in_ready", 32'(in_ready), 32'h0);
        check_eq("full_count", 32'(count), 32'd3);
        check_eq("full_head", 32'(out_data), 32'hAAAA);
        cycle(1'b1, 16'hDDDD, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Simultaneous in/out while full keeps occupancy at DEPTH.
        cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBBB, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCCC, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        check_eq("swap_count", 32'(count), 32'd3);
        check_eq("swap_head", 32'(out_data), 32'hBBBB);
        idle(5, 1'b1);

        // Flush with two words inside and a word offered.
        cycle(1'b1, 16'h0A0A, 1'b0, 1'b0);
        cycle(1'b1, 16'h0B0B, 1'b0, 1'b0);
        cycle(1'b1, 16'h0C0C, 1'b0, 1'b1);
        check_eq("flush_count", 32'(count), 32'h0);
        check_eq("flush_out_valid", 32'(out_valid), 32'h0);
        idle(3, 1'b1);

        // Asynchronous reset between edges with two words in flight.
        cycle(1'b1, 16'h5555, 1'b0, 1'b0);
        cycle(1'b1, 16'h6666, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'h0);
        check_eq("arst_out_data", 32'(out_data), 32'(RDATA));
        check_eq("arst_count", 32'(count), 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 16'h7777, 1'b1, 1'b0);
        idle(4, 1'b1);

        // Randomized traffic, 50% valid and 50% ready.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        idle(DEPTH + 2, 1'b1);
        check_eq("final_drain", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3, number of register stages (>=1).
REQ-003 SHALL have parameter RESET_DATA, default 0, WIDTH-bit value loaded into every data register on reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream data valid.
REQ-007 SHALL have port in_ready  output  1  chain can accept in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  upstream data.
REQ-009 SHALL have port out_valid  output  1  last stage holds valid data.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  last-stage data register.
REQ-012 SHALL have port flush  input  1  synchronous clear of all stage valids.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of stages holding valid data.

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) one valid bit v[i] and one WIDTH-bit data register d[i]; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data.
REQ-015 SHALL compute advance enable a[DEPTH-1] = !v[DEPTH-1] | out_ready, and a[i] = !v[i] | a[i+1] for i<DEPTH-1 (bubble collapsing, combinational ready path).
REQ-016 SHALL drive in_ready = a[0] & !flush.
REQ-017 SHALL, when a[i] is 1 and flush is 0, load v[i] from the preceding stage valid (in_valid for stage 0) and load d[i] from preceding data only if that valid is 1; d[i] SHALL otherwise hold.
REQ-018 SHALL transfer in on in_valid & in_ready and out on out_valid & out_ready.
REQ-019 SHALL give latency of exactly DEPTH cycles when empty and unstalled: accepted at edge t, out_valid high after edge t+DEPTH-1.
REQ-020 SHALL sustain one transfer per cycle with in_valid and out_ready held high.
REQ-021 SHALL never drop, duplicate or reorder accepted data; order out equals order in.
REQ-022 SHALL, when full (count==DEPTH) and out_ready=0, hold all state and drive in_ready=0.
REQ-023 SHALL, when full and out_ready=1, accept a new input in the same cycle (simultaneous in/out), count unchanged.
REQ-024 SHALL, on flush=1 at an edge, clear all v[i] to 0, leave d[i] unchanged, accept no input; out_valid remains as-is during the flush cycle and an out transfer in that cycle is still counted delivered.
REQ-025 SHALL update count as count + in_xfer - out_xfer, forced to 0 on flush; count SHALL equal the population of v[].
REQ-026 SHALL drive out_data = d[DEPTH-1] regardless of out_valid.

Reset
REQ-027 SHALL on reset=1 clear all v[i] to 0, set all d[i] to RESET_DATA, count to 0, independent of clk.
REQ-028 SHALL therefore drive out_valid=0, out_data=RESET_DATA, count=0 during reset; in_ready SHALL be 1 if flush=0.
REQ-029 SHALL discard in-flight data when reset asserts mid-operation; first accepted word after deassertion exits after DEPTH cycles.

Structure
REQ-030 SHALL place the count-width helper (clog2-based) in the shared package fmdsp_pkg; no typedefs required.
REQ-031 SHALL instantiate DEPTH copies of sub-module pipe_stage (one valid bit + data register, load enable, async active-high reset to RESET_DATA) via generate loop.
REQ-032 SHALL keep all ready logic in pipe_stage_chain, outside pipe_stage.

Verification (WIDTH=16, DEPTH=3)
REQ-033 SHALL cover: reset, then in 0x0001..0x0005 back-to-back, out_ready=1 -> out_valid first high after 3rd edge, outputs 0x0001..0x0005 consecutive, count peaks 3.
REQ-034 SHALL cover: out_ready=0, push 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> in_ready=0 after 3 accepts, count=3, 0xDDDD held; release out_ready -> 0xAAAA..0xDDDD in order.
REQ-035 SHALL cover: full, out_ready=1 and in_valid=1 with 0x1234 same cycle -> 0xAAAA out, 0x1234 accepted, count stays 3.
REQ-036 SHALL cover: chain holding 2 words, flush=1 one cycle with in_valid=1 -> in_ready=0, count=0 and out_valid=0 next cycle, input not accepted.
REQ-037 SHALL cover: reset asserted asynchronously between edges with count=2 -> out_valid=0, out_data=0x0000, count=0 immediately.
REQ-038 SHALL cover: random in_valid/out_ready 50% for 10000 cycles -> scoreboard exact in-order match, count always equals pushes minus pops.
